// File: rtl/voting_pkg.sv
// Shared widths, defaults and types for the four-candidate voting unit.
package voting_pkg;
  localparam int CNT_W = 8;
  localparam int NUM_CAND = 4;
  localparam int DEF_HOLD_CYCLES = 10;
  localparam int DEF_FLASH_CYCLES = 10;

  typedef logic [CNT_W-1:0] tally_t;

  localparam tally_t TALLY_MAX = '1;
endpackage

// File: rtl/voting_button_ctrl.sv
// Per-button press counter; pulses once when a press has been held long enough.
module voting_button_ctrl #(
  parameter int HOLD_CYCLES = voting_pkg::DEF_HOLD_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic valid
);
  localparam int CW = $clog2(HOLD_CYCLES + 2);
  localparam logic [CW-1:0] SAT = CW'(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!button) begin
      count <= '0;
    end else if (count != SAT) begin
      count <= count + 1'b1;
    end
  end

  // Saturation past HOLD_CYCLES keeps a long hold to a single pulse.
  assign valid = button && (count == LAST);
endmodule

// File: rtl/voting_machine.sv
// Four-candidate voting unit: tallies, acknowledge flash and LED display.
module voting_machine #(
  parameter int HOLD_CYCLES = voting_pkg::DEF_HOLD_CYCLES,
  parameter int FLASH_CYCLES = voting_pkg::DEF_FLASH_CYCLES
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        mode,
  input  logic                        button1,
  input  logic                        button2,
  input  logic                        button3,
  input  logic                        button4,
  output logic [voting_pkg::CNT_W-1:0] led
);
  import voting_pkg::*;

  localparam int FW = $clog2(FLASH_CYCLES + 1);

  logic [NUM_CAND-1:0] buttons;
  logic [NUM_CAND-1:0] pulse;
  logic [NUM_CAND-1:0] accept;
  tally_t              tally [NUM_CAND];
  logic [FW-1:0]       flash;
  tally_t              led_next;

  assign buttons = {button4, button3, button2, button1};
  assign accept  = pulse & {NUM_CAND{~mode}};

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_btn
    voting_button_ctrl #(
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_btn (
      .clock (clock),
      .reset (reset),
      .button(buttons[g]),
      .valid (pulse[g])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CAND; i++) begin
        if (accept[i] && tally[i] != TALLY_MAX)
          tally[i] <= tally[i] + 1'b1;
      end
    end
  end

  // Result mode kills any pending flash so it cannot resume later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flash <= '0;
    end else if (mode) begin
      flash <= '0;
    end else if (|accept) begin
      flash <= FW'(FLASH_CYCLES);
    end else if (flash != '0) begin
      flash <= flash - 1'b1;
    end
  end

  always_comb begin
    led_next = '0;
    if (mode) begin
      for (int i = NUM_CAND - 1; i >= 0; i--) begin
        if (buttons[i]) led_next = tally[i];
      end
    end else if (flash != '0) begin
      led_next = '1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led <= '0;
    end else begin
      led <= led_next;
    end
  end
endmodule

// File: tb/tb_voting_machine.sv
// Directed scoreboard bench for voting_machine.
module tb_voting_machine;
  logic       clock;
  logic       reset;
  logic       mode;
  logic [3:0] btn;
  logic [7:0] led;

  typedef struct {
    logic [7:0] v;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;

  voting_machine dut (
    .clock  (clock),
    .reset  (reset),
    .mode   (mode),
    .button1(btn[0]),
    .button2(btn[1]),
    .button3(btn[2]),
    .button4(btn[3]),
    .led    (led)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (led !== e.v) begin
        failures++;
        $display("FAIL %s: led=%h expected=%h", e.tag, led, e.v);
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic expect_led(input logic [7:0] v, input string tag);
    exp_t x;
    x.v = v;
    x.tag = tag;
    exp_q.push_back(x);
  endtask

  task automatic vote(input logic [3:0] mask);
    mode = 1'b0;
    btn = mask;
    tick(20);
    btn = '0;
    tick(2);
  endtask

  task automatic fast_votes(input int n);
    mode = 1'b0;
    repeat (n) begin
      btn[3] = 1'b1;
      tick(10);
      btn[3] = 1'b0;
      tick(1);
    end
  endtask

  task automatic show(input logic [3:0] mask, input logic [7:0] v,
                      input string tag);
    mode = 1'b1;
    btn = mask;
    tick(1);
    expect_led(v, tag);
    btn = '0;
    tick(1);
  endtask

  initial begin
    reset = 1'b1;
    mode = 1'b0;
    btn = '0;
    expect_led(8'h00, "reset");
    #200;
    checks++;
    if (led !== 8'h00) begin
      failures++;
      $display("FAIL reset_direct: led=%h", led);
    end
    reset = 1'b0;
    tick(1);
    for (int k = 0; k < 4; k++) show(4'(1 << k), 8'h00, "empty_tally");

    mode = 1'b0;
    btn = 4'b0001;
    tick(1);
    btn = '0;
    tick(1);
    btn = 4'b0001;
    tick(10);
    expect_led(8'h00, "pre_flash");
    for (int i = 0; i < 10; i++) begin
      tick(1);
      expect_led(8'hFF, "flash");
    end
    tick(1);
    expect_led(8'h00, "flash_end");
    tick(5);
    expect_led(8'h00, "hold_no_revote");
    btn = '0;
    tick(2);
    show(4'b0001, 8'd1, "tally1");

    vote(4'b0010);
    vote(4'b0010);
    show(4'b0010, 8'd2, "tally2");
    show(4'b0001, 8'd1, "tally1_again");
    show(4'b0100, 8'd0, "tally3_zero");

    mode = 1'b1;
    btn = 4'b0100;
    tick(20);
    expect_led(8'h00, "result_hold");
    btn = '0;
    mode = 1'b0;
    tick(1);
    expect_led(8'h00, "no_flash");
    tick(2);
    show(4'b0100, 8'd0, "tally3_still_zero");

    mode = 1'b0;
    btn = 4'b1100;
    tick(10);
    expect_led(8'h00, "dual_pre");
    for (int i = 0; i < 10; i++) begin
      tick(1);
      expect_led(8'hFF, "dual_flash");
    end
    tick(1);
    expect_led(8'h00, "dual_flash_end");
    tick(8);
    expect_led(8'h00, "dual_single_flash");
    btn = '0;
    tick(2);
    show(4'b0100, 8'd1, "tally3");
    show(4'b1000, 8'd1, "tally4");
    show(4'b0110, 8'd2, "priority");

    fast_votes(253);
    show(4'b1000, 8'hFE, "tally4_254");
    fast_votes(1);
    show(4'b1000, 8'hFF, "tally4_255");
    fast_votes(46);
    show(4'b1000, 8'hFF, "tally4_sat");

    mode = 1'b0;
    btn = 4'b0001;
    tick(5);
    mode = 1'b1;
    tick(1);
    expect_led(8'd1, "pre_reset");
    tick(1);
    #2;
    reset = 1'b1;
    expect_led(8'h00, "async_reset");
    #1;
    checks++;
    if (led !== 8'h00) begin
      failures++;
      $display("FAIL async_reset_direct: led=%h", led);
    end
    tick(2);
    expect_led(8'h00, "reset_held");
    checks++;
    if (led !== 8'h00) begin
      failures++;
      $display("FAIL reset_held_direct: led=%h", led);
    end
    mode = 1'b0;
    reset = 1'b0;
    tick(9);
    expect_led(8'h00, "fresh_count");
    tick(1);
    expect_led(8'h00, "post_reset_vote");
    tick(1);
    expect_led(8'hFF, "post_reset_flash");
    btn = '0;
    tick(2);
    show(4'b0001, 8'd1, "tally1_post_reset");
    show(4'b1000, 8'd0, "tally4_cleared");
    show(4'b0010, 8'd0, "tally2_cleared");

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
